// File: rtl/viterbi_dec_k3.sv
// rtl/viterbi_dec_k3.sv - hard-decision K=3 rate-1/2 register-exchange Viterbi decoder
// Define VIT_ERR_CNT_EN to add the saturating corrected-symbol counter on err_ct_o.
module viterbi_dec_k3 #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_decoder_i,
  input  logic [1:0]  d_i,
  output logic        decoder_o,
  output logic        valid_o
`ifdef VIT_ERR_CNT_EN
  ,
  output logic [15:0] err_ct_o
`endif
);

  localparam int FILL_W = $clog2(TB_DEPTH);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_DEPTH - 1);

  logic [PM_W-1:0]     pm_q   [4];
  logic [PM_W-1:0]     pm_raw [4];
  logic [PM_W-1:0]     pm_d   [4];
  // The oldest bit is emitted from path_d, so only TB_DEPTH-1 bits are kept.
  logic [TB_DEPTH-2:0] path_q [4];
  logic [TB_DEPTH-1:0] path_d [4];
`ifdef VIT_ERR_CNT_EN
  logic [1:0]          wbm    [4];
`endif

  logic [FILL_W-1:0]   fill_q;
  logic                dec_q;
  logic                valid_q;
  logic                valid_d;
  logic                all_msb;
  logic                sel01;
  logic                sel23;
  logic [PM_W-1:0]     min01;
  logic [PM_W-1:0]     min23;
  logic [1:0]          best;

  for (genvar n = 0; n < 4; n++) begin : g_acs
    localparam logic       A  = (n >= 2);
    localparam logic       B  = ((n % 2) == 1);
    localparam logic [1:0] P0 = {B, 1'b0};
    localparam logic [1:0] P1 = {B, 1'b1};
    // Expected {c1,c0} leaving {B,0} and {B,1} with input A.
    localparam logic [1:0] E0 = {A ^ B, A};
    localparam logic [1:0] E1 = {A ^ B ^ 1'b1, A ^ 1'b1};

    logic [1:0]      x0;
    logic [1:0]      x1;
    logic [1:0]      bm0;
    logic [1:0]      bm1;
    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;
    logic            take1;

    assign x0    = d_i ^ E0;
    assign x1    = d_i ^ E1;
    assign bm0   = {x0[1] & x0[0], x0[1] ^ x0[0]};
    assign bm1   = {x1[1] & x1[0], x1[1] ^ x1[0]};
    assign cand0 = pm_q[P0] + {{(PM_W-2){1'b0}}, bm0};
    assign cand1 = pm_q[P1] + {{(PM_W-2){1'b0}}, bm1};
    // Strict compare: ties resolve to the predecessor with LSB 0.
    assign take1 = (cand1 < cand0);

    assign pm_raw[n] = take1 ? cand1 : cand0;
    assign path_d[n] = take1 ? {path_q[P1], A} : {path_q[P0], A};
    assign pm_d[n]   = all_msb ? {1'b0, pm_raw[n][PM_W-2:0]} : pm_raw[n];
`ifdef VIT_ERR_CNT_EN
    assign wbm[n]    = take1 ? bm1 : bm0;
`endif
  end

  assign all_msb = pm_raw[0][PM_W-1] & pm_raw[1][PM_W-1] &
                   pm_raw[2][PM_W-1] & pm_raw[3][PM_W-1];

  // Min-of-4 with ties going to the lowest state index.
  assign sel01 = (pm_d[1] < pm_d[0]);
  assign sel23 = (pm_d[3] < pm_d[2]);
  assign min01 = sel01 ? pm_d[1] : pm_d[0];
  assign min23 = sel23 ? pm_d[3] : pm_d[2];
  assign best  = (min23 < min01) ? {1'b1, sel23} : {1'b0, sel01};

  assign valid_d = enable_decoder_i && (fill_q == FILL_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_W'(8);
        path_q[i] <= '0;
      end
      fill_q  <= '0;
      dec_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (enable_decoder_i) begin
        for (int i = 0; i < 4; i++) begin
          pm_q[i]   <= pm_d[i];
          path_q[i] <= path_d[i][TB_DEPTH-2:0];
        end
        if (fill_q != FILL_MAX) begin
          fill_q <= fill_q + FILL_W'(1);
        end
        dec_q <= path_d[best][TB_DEPTH-1];
      end
    end
  end

  assign decoder_o = dec_q;
  assign valid_o   = valid_q;

`ifdef VIT_ERR_CNT_EN
  logic [15:0] err_ct_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_ct_q <= '0;
    end else if (enable_decoder_i && (wbm[best] != 2'd0) && (err_ct_q != 16'hFFFF)) begin
      err_ct_q <= err_ct_q + 16'd1;
    end
  end

  assign err_ct_o = err_ct_q;
`endif

endmodule

// File: tb/tb_viterbi_dec_k3.sv
// tb/tb_viterbi_dec_k3.sv - scoreboard bench for viterbi_dec_k3
module tb_viterbi_dec_k3;
  localparam int TBD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [1:0] d   = 2'b00;
  logic       dec_o;
  logic       val_o;
`ifdef VIT_ERR_CNT_EN
  logic [15:0] err_ct;
`endif

  always #5 clk = ~clk;

  viterbi_dec_k3 #(.TB_DEPTH(TBD), .PM_W(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_decoder_i (en),
    .d_i              (d),
    .decoder_o        (dec_o),
    .valid_o          (val_o)
`ifdef VIT_ERR_CNT_EN
    ,
    .err_ct_o         (err_ct)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_v_q [$];   // {hold_check, valid} per driven cycle
  logic       exp_bit_q [$];
  logic       hist [$];
  int         k = 0;
  logic       last_valid = 1'b0;
  logic       last_bit = 1'b0;

  logic       rnd_data [1000];
  int         gap_pos [5];
  int         gap_len [5];
  logic [1:0] t2_sym [7] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
  logic       t2_bit [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc_sym(input logic u, input logic [1:0] s);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  task automatic drive_sym(input logic [1:0] sym, input logic u);
    @(negedge clk);
    en = 1'b1;
    d  = sym;
    hist.push_back(u);
    if (k >= TBD - 1) begin
      exp_v_q.push_back(2'b01);
      exp_bit_q.push_back(hist[k - (TBD - 1)]);
      last_valid = 1'b1;
    end else begin
      exp_v_q.push_back(2'b00);
      last_valid = 1'b0;
    end
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en = 1'b0;
      d  = 2'b00;
      exp_v_q.push_back({last_valid, 1'b0});
    end
  endtask

  task automatic drain();
    idle(2);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    en  = 1'b0;
    d   = 2'b00;
    rst = 1'b0;
    #1;
    chk("reset_valid", {15'd0, val_o}, 16'd0);
    chk("reset_dec", {15'd0, dec_o}, 16'd0);
`ifdef VIT_ERR_CNT_EN
    chk("reset_err_ct", err_ct, 16'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    k = 0;
    hist.delete();
    last_valid = 1'b0;
  endtask

  task automatic run_table(input bit flip3);
    logic [1:0] sym;
    logic       u;
    for (int i = 0; i < 36; i++) begin
      sym = (i < 7) ? t2_sym[i] : 2'b00;
      u   = (i < 6) ? t2_bit[i] : 1'b0;
      if (flip3 && i == 2) sym = 2'b10;
      drive_sym(sym, u);
    end
  endtask

  task automatic run_random(input bit gaps, input int first, input int count, input bit inject);
    logic [1:0] s;
    logic [1:0] sym;
    int         j;
    s = 2'b00;
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        for (int g = 0; g < 5; g++) begin
          if (gap_pos[g] == i) idle(gap_len[g]);
        end
      end
      j   = first + i;
      sym = enc_sym(rnd_data[j], s);
      s   = {rnd_data[j], s[1]};
      if (inject && (i % 8) == 3) sym[(i / 8) % 2] = ~sym[(i / 8) % 2];
      drive_sym(sym, rnd_data[j]);
    end
  endtask

  // Monitor: consumes one expectation per driven cycle, decoded bits only when valid.
  initial begin
    logic [1:0] e;
    logic       b;
    forever begin
      @(posedge clk);
      #1;
      if (exp_v_q.size() > 0) begin
        e = exp_v_q.pop_front();
        chk("valid", {15'd0, val_o}, {15'd0, e[0]});
        if (e[0]) begin
          if (exp_bit_q.size() == 0) begin
            chk("bit_queue_underrun", 16'd1, 16'd0);
          end else begin
            b = exp_bit_q.pop_front();
            chk("decoded_bit", {15'd0, dec_o}, {15'd0, b});
            last_bit = b;
          end
        end else if (e[1]) begin
          chk("gap_hold", {15'd0, dec_o}, {15'd0, last_bit});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1000; i++) rnd_data[i] = 1'($urandom_range(0, 1));
    for (int g = 0; g < 5; g++) begin
      gap_pos[g] = 100 + g * 180 + int'($urandom_range(0, 50));
      gap_len[g] = int'($urandom_range(1, 7));
    end

    do_reset();

    for (int i = 0; i < 40; i++) drive_sym(2'b00, 1'b0);
    drain();
`ifdef VIT_ERR_CNT_EN
    chk("err_ct_zeros", err_ct, 16'd0);
`endif
    do_reset();

    run_table(1'b0);
    drain();
`ifdef VIT_ERR_CNT_EN
    chk("err_ct_clean", err_ct, 16'd0);
`endif
    do_reset();

    run_table(1'b1);
    drain();
`ifdef VIT_ERR_CNT_EN
    chk("err_ct_one_flip", err_ct, 16'd1);
`endif
    do_reset();

    run_random(1'b0, 0, 1000, 1'b1);
    drain();
    do_reset();

    run_random(1'b1, 0, 1000, 1'b1);
    drain();
    do_reset();

    run_random(1'b0, 0, 20, 1'b0);
    @(posedge clk);
    #2;
    do_reset();
    run_random(1'b0, 500, 60, 1'b0);
    drain();

    chk("bits_outstanding", 16'(exp_bit_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
